// File: rtl/bure_mem_arbiter_if.sv
// -----------------------------------------------------------------------------
// bure_mem_arbiter_if
//
// Bundles every bus signal around the memory-port arbiter.
//   if_*  : instruction-fetch request/response plus the fetch flush
//   dm_*  : data-memory request/response (loads and stores)
//   mem_* : the single shared memory port
//
// Handshake rule for every *_req channel: a transfer happens in a cycle where
// valid and ready are both 1 at the rising clock edge; the initiator holds
// valid and payload stable until that cycle, and never withdraws a valid.
// Responses (*_rsp_valid) are single-cycle pulses with no back-pressure.
//
// Modports:
//   slave  : the arbiter's view (takes requester/memory inputs, drives outputs)
//   master : the environment's view (requesters + memory)
// -----------------------------------------------------------------------------
interface bure_mem_arbiter_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
);
    logic                      if_req_valid;
    logic                      if_req_ready;
    logic [ADDR_WIDTH-1:0]     if_req_addr;
    logic                      if_flush;
    logic                      if_rsp_valid;
    logic [DATA_WIDTH-1:0]     if_rsp_data;

    logic                      dm_req_valid;
    logic                      dm_req_ready;
    logic [ADDR_WIDTH-1:0]     dm_req_addr;
    logic                      dm_req_we;
    logic [DATA_WIDTH/8-1:0]   dm_req_be;
    logic [DATA_WIDTH-1:0]     dm_req_wdata;
    logic                      dm_rsp_valid;
    logic [DATA_WIDTH-1:0]     dm_rsp_rdata;

    logic                      mem_req_valid;
    logic                      mem_req_ready;
    logic [ADDR_WIDTH-1:0]     mem_req_addr;
    logic                      mem_req_we;
    logic [DATA_WIDTH/8-1:0]   mem_req_be;
    logic [DATA_WIDTH-1:0]     mem_req_wdata;
    logic                      mem_rsp_valid;
    logic [DATA_WIDTH-1:0]     mem_rsp_rdata;

    modport slave (
        input  if_req_valid, if_req_addr, if_flush,
        input  dm_req_valid, dm_req_addr, dm_req_we, dm_req_be, dm_req_wdata,
        input  mem_req_ready, mem_rsp_valid, mem_rsp_rdata,
        output if_req_ready, if_rsp_valid, if_rsp_data,
        output dm_req_ready, dm_rsp_valid, dm_rsp_rdata,
        output mem_req_valid, mem_req_addr, mem_req_we, mem_req_be, mem_req_wdata
    );

    modport master (
        output if_req_valid, if_req_addr, if_flush,
        output dm_req_valid, dm_req_addr, dm_req_we, dm_req_be, dm_req_wdata,
        output mem_req_ready, mem_rsp_valid, mem_rsp_rdata,
        input  if_req_ready, if_rsp_valid, if_rsp_data,
        input  dm_req_ready, dm_rsp_valid, dm_rsp_rdata,
        input  mem_req_valid, mem_req_addr, mem_req_we, mem_req_be, mem_req_wdata
    );
endinterface

// File: rtl/bure_mem_arbiter.sv
// -----------------------------------------------------------------------------
// bure_mem_arbiter
//
// Shares one memory port between instruction fetch (IF) and data memory (DM).
// One transaction is held at a time; the winning request is registered and
// then presented on mem_req_*. DM wins contention unless IF has been passed
// over STARVE_LIMIT times in a row. A fetch flush swallows the response of a
// fetch already owned by the arbiter (the memory transaction still completes).
//
// Ports:
//   clk, rst_n       : clock, asynchronous active-low reset
//   bus (slave)      : if_*, dm_*, mem_* handshake/bus signals
//   dbg_state        : FSM state (0 IDLE, 1 REQ, 2 WAIT_RSP)
//   dbg_starve_cnt   : consecutive DM grants while IF was waiting
//   dbg_owner        : owner of the held transaction (0 IF, 1 DM)
//   dbg_drop         : pending fetch response will be swallowed
// -----------------------------------------------------------------------------
module bure_mem_arbiter #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 32,
    parameter int STARVE_LIMIT = 4,
    localparam int CNT_W       = $clog2(STARVE_LIMIT + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    bure_mem_arbiter_if.slave bus,
    output logic [1:0]        dbg_state,
    output logic [CNT_W-1:0]  dbg_starve_cnt,
    output logic              dbg_owner,
    output logic              dbg_drop
);
    localparam int BE_W = DATA_WIDTH / 8;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

    logic [1:0]            state;
    logic [1:0]            state_nxt;
    logic [CNT_W-1:0]      starve_cnt;
    logic                  owner;
    logic                  drop;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic                  req_we;
    logic [BE_W-1:0]       req_be;
    logic [DATA_WIDTH-1:0] req_wdata;

    logic rsp_fire;
    logic in_window;
    logic if_cand;
    logic starve_full;
    logic grant_if;
    logic grant_dm;
    logic accept;

    // The accept window is IDLE, or the response cycle of WAIT_RSP so a new
    // request can be taken back-to-back with the completing one.
    always_comb begin
        rsp_fire    = (state == ST_WAIT) && bus.mem_rsp_valid;
        in_window   = (state == ST_IDLE) || rsp_fire;
        if_cand     = bus.if_req_valid && !bus.if_flush;
        starve_full = (starve_cnt == CNT_MAX);
        grant_if    = in_window && if_cand && (!bus.dm_req_valid || starve_full);
        grant_dm    = in_window && bus.dm_req_valid && !grant_if;
        accept      = grant_if || grant_dm;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (accept) state_nxt = ST_REQ;
            ST_REQ:  if (bus.mem_req_ready) state_nxt = ST_WAIT;
            ST_WAIT: if (bus.mem_rsp_valid) state_nxt = accept ? ST_REQ : ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Registered request; fetches are always full-word reads.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner     <= 1'b0;
            req_addr  <= '0;
            req_we    <= 1'b0;
            req_be    <= '0;
            req_wdata <= '0;
        end else if (accept) begin
            owner <= grant_dm;
            if (grant_dm) begin
                req_addr  <= bus.dm_req_addr;
                req_we    <= bus.dm_req_we;
                req_be    <= bus.dm_req_be;
                req_wdata <= bus.dm_req_wdata;
            end else begin
                req_addr  <= bus.if_req_addr;
                req_we    <= 1'b0;
                req_be    <= '1;
                req_wdata <= '0;
            end
        end
    end

    // Counts DM wins that left a waiting fetch behind; any fetch grant resets it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt <= '0;
        end else if (grant_if) begin
            starve_cnt <= '0;
        end else if (grant_dm && bus.if_req_valid && !starve_full) begin
            starve_cnt <= starve_cnt + CNT_W'(1);
        end
    end

    // drop marks the held fetch as stale. It is cleared by the response it
    // refers to; a flush coinciding with that response is handled on the
    // combinational response path instead.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop <= 1'b0;
        end else if (rsp_fire) begin
            drop <= 1'b0;
        end else if (bus.if_flush && !owner && ((state == ST_REQ) || (state == ST_WAIT))) begin
            drop <= 1'b1;
        end
    end

    assign bus.if_req_ready  = grant_if;
    assign bus.dm_req_ready  = grant_dm;

    assign bus.mem_req_valid = (state == ST_REQ);
    assign bus.mem_req_addr  = req_addr;
    assign bus.mem_req_we    = req_we;
    assign bus.mem_req_be    = req_be;
    assign bus.mem_req_wdata = req_wdata;

    // Response path is purely combinational; stray responses outside
    // WAIT_RSP are not routed anywhere.
    assign bus.if_rsp_valid  = rsp_fire && !owner && !drop && !bus.if_flush;
    assign bus.dm_rsp_valid  = rsp_fire && owner;
    assign bus.if_rsp_data   = owner ? '0 : bus.mem_rsp_rdata;
    assign bus.dm_rsp_rdata  = owner ? bus.mem_rsp_rdata : '0;

    assign dbg_state      = state;
    assign dbg_starve_cnt = starve_cnt;
    assign dbg_owner      = owner;
    assign dbg_drop       = drop;
endmodule

// File: tb/tb_bure_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_bure_mem_arbiter
//
// Directed bench for bure_mem_arbiter: a cycle table covers single fetch,
// contention, a DM load, stray responses and flush masking; hand-written
// sequences cover starvation, back-pressure, flush and mid-transaction reset.
// -----------------------------------------------------------------------------
module tb_bure_mem_arbiter;
    localparam logic [1:0] S_IDLE = 2'd0;

    logic       clk;
    logic       rst_n;
    logic [1:0] dbg_state;
    logic [2:0] dbg_starve_cnt;
    logic       dbg_owner;
    logic       dbg_drop;

    int total = 0;
    int bad   = 0;

    bure_mem_arbiter_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus ();

    bure_mem_arbiter #(
        .DATA_WIDTH  (32),
        .ADDR_WIDTH  (32),
        .STARVE_LIMIT(4)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .bus           (bus),
        .dbg_state     (dbg_state),
        .dbg_starve_cnt(dbg_starve_cnt),
        .dbg_owner     (dbg_owner),
        .dbg_drop      (dbg_drop)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- helpers ----------------
    task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.if_req_valid  = 1'b0;
        bus.if_req_addr   = '0;
        bus.if_flush      = 1'b0;
        bus.dm_req_valid  = 1'b0;
        bus.dm_req_addr   = '0;
        bus.dm_req_we     = 1'b0;
        bus.dm_req_be     = '0;
        bus.dm_req_wdata  = '0;
        bus.mem_req_ready = 1'b0;
        bus.mem_rsp_valid = 1'b0;
        bus.mem_rsp_rdata = '0;
    endtask

    function automatic logic [4:0] ctl();
        return {bus.if_req_ready, bus.dm_req_ready, bus.mem_req_valid,
                bus.if_rsp_valid, bus.dm_rsp_valid};
    endfunction

    // ---------------- vector table ----------------
    typedef struct {
        logic        if_v;
        logic [31:0] if_a;
        logic        if_fl;
        logic        dm_v;
        logic [31:0] dm_a;
        logic        dm_we;
        logic [3:0]  dm_be;
        logic [31:0] dm_wd;
        logic        m_rdy;
        logic        m_rv;
        logic [31:0] m_rd;
        logic [4:0]  e_ctl;   // {if_ready, dm_ready, mem_valid, if_rsp_valid, dm_rsp_valid}
        logic [31:0] e_addr;
        logic        e_we;
        logic [3:0]  e_be;
        logic [31:0] e_wd;
        logic [31:0] e_rd;
        logic        chk_rd;
    } vec_t;

    function automatic vec_t mk(
        input logic if_v, input logic [31:0] if_a, input logic if_fl,
        input logic dm_v, input logic [31:0] dm_a, input logic dm_we,
        input logic [3:0] dm_be, input logic [31:0] dm_wd,
        input logic m_rdy, input logic m_rv, input logic [31:0] m_rd,
        input logic [4:0] e_ctl, input logic [31:0] e_addr, input logic e_we,
        input logic [3:0] e_be, input logic [31:0] e_wd, input logic [31:0] e_rd,
        input logic chk_rd);
        vec_t v;
        v.if_v = if_v;   v.if_a = if_a;   v.if_fl = if_fl;
        v.dm_v = dm_v;   v.dm_a = dm_a;   v.dm_we = dm_we;
        v.dm_be = dm_be; v.dm_wd = dm_wd;
        v.m_rdy = m_rdy; v.m_rv = m_rv;   v.m_rd = m_rd;
        v.e_ctl = e_ctl; v.e_addr = e_addr; v.e_we = e_we;
        v.e_be = e_be;   v.e_wd = e_wd;   v.e_rd = e_rd; v.chk_rd = chk_rd;
        return v;
    endfunction

    localparam int NV = 15;
    vec_t vecs[NV];

    // ---------------- starvation expectations ----------------
    logic exp_if_grant[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    int   exp_cnt[6]      = '{1, 2, 3, 4, 0, 1};

    // Safety net: the flow below is fully bounded, this only guards a hang.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic gi, gd, pend, nxt_pend;
        int   grants;

        // Single fetch
        vecs[0]  = mk(0, 0, 0,  0, 0, 0, 4'h0, 0,  0, 0, 0,  5'b00000, 0, 0, 4'h0, 0, 0, 0);
        vecs[1]  = mk(1, 32'h100, 0,  0, 0, 0, 4'h0, 0,  0, 0, 0,  5'b10000, 0, 0, 4'h0, 0, 0, 0);
        vecs[2]  = mk(0, 0, 0,  0, 0, 0, 4'h0, 0,  1, 0, 0,  5'b00100, 32'h100, 0, 4'hF, 0, 0, 0);
        vecs[3]  = mk(0, 0, 0,  0, 0, 0, 4'h0, 0,  0, 1, 32'hDEADBEEF,  5'b00010, 0, 0, 4'h0, 0, 32'hDEADBEEF, 1);
        // Contention: DM store wins, IF taken in the response cycle
        vecs[4]  = mk(1, 32'h104, 0,  1, 32'h200, 1, 4'b0011, 32'h1234,  0, 0, 0,  5'b01000, 0, 0, 4'h0, 0, 0, 0);
        vecs[5]  = mk(1, 32'h104, 0,  0, 0, 0, 4'h0, 0,  1, 0, 0,  5'b00100, 32'h200, 1, 4'b0011, 32'h1234, 0, 0);
        vecs[6]  = mk(1, 32'h104, 0,  0, 0, 0, 4'h0, 0,  0, 1, 0,  5'b10001, 0, 0, 4'h0, 0, 0, 0);
        vecs[7]  = mk(0, 0, 0,  0, 0, 0, 4'h0, 0,  1, 0, 0,  5'b00100, 32'h104, 0, 4'hF, 0, 0, 0);
        vecs[8]  = mk(0, 0, 0,  0, 0, 0, 4'h0, 0,  0, 1, 32'hCAFEF00D,  5'b00010, 0, 0, 4'h0, 0, 32'hCAFEF00D, 1);
        // DM load
        vecs[9]  = mk(0, 0, 0,  1, 32'h208, 0, 4'hF, 0,  0, 0, 0,  5'b01000, 0, 0, 4'h0, 0, 0, 0);
        vecs[10] = mk(0, 0, 0,  0, 0, 0, 4'h0, 0,  1, 0, 0,  5'b00100, 32'h208, 0, 4'hF, 0, 0, 0);
        vecs[11] = mk(0, 0, 0,  0, 0, 0, 4'h0, 0,  0, 1, 32'h55AA,  5'b00001, 0, 0, 4'h0, 0, 32'h55AA, 1);
        // Stray response while idle, then flush masking an idle fetch
        vecs[12] = mk(0, 0, 0,  0, 0, 0, 4'h0, 0,  0, 1, 32'h99,  5'b00000, 0, 0, 4'h0, 0, 0, 0);
        vecs[13] = mk(1, 32'h108, 1,  0, 0, 0, 4'h0, 0,  0, 0, 0,  5'b00000, 0, 0, 4'h0, 0, 0, 0);
        vecs[14] = mk(0, 0, 0,  0, 0, 0, 4'h0, 0,  0, 0, 0,  5'b00000, 0, 0, 4'h0, 0, 0, 0);

        // ---------------- reset ----------------
        idle_inputs();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_state", 72'(dbg_state), 72'(S_IDLE));
        chk("rst_ctl", 72'(ctl()), 72'(5'b00000));
        chk("rst_starve", 72'(dbg_starve_cnt), 72'(0));
        chk("rst_mem_addr", 72'(bus.mem_req_addr), 72'(0));
        rst_n = 1'b1;
        tick();

        // ---------------- table ----------------
        for (int i = 0; i < NV; i++) begin
            bus.if_req_valid  = vecs[i].if_v;
            bus.if_req_addr   = vecs[i].if_a;
            bus.if_flush      = vecs[i].if_fl;
            bus.dm_req_valid  = vecs[i].dm_v;
            bus.dm_req_addr   = vecs[i].dm_a;
            bus.dm_req_we     = vecs[i].dm_we;
            bus.dm_req_be     = vecs[i].dm_be;
            bus.dm_req_wdata  = vecs[i].dm_wd;
            bus.mem_req_ready = vecs[i].m_rdy;
            bus.mem_rsp_valid = vecs[i].m_rv;
            bus.mem_rsp_rdata = vecs[i].m_rd;
            @(negedge clk);
            chk($sformatf("vec%0d_ctl", i), 72'(ctl()), 72'(vecs[i].e_ctl));
            if (vecs[i].e_ctl[2]) begin
                chk($sformatf("vec%0d_addr", i), 72'(bus.mem_req_addr), 72'(vecs[i].e_addr));
                chk($sformatf("vec%0d_we_be", i), 72'({bus.mem_req_we, bus.mem_req_be}),
                    72'({vecs[i].e_we, vecs[i].e_be}));
                if (vecs[i].e_we)
                    chk($sformatf("vec%0d_wdata", i), 72'(bus.mem_req_wdata), 72'(vecs[i].e_wd));
            end
            if (vecs[i].e_ctl[1])
                chk($sformatf("vec%0d_if_data", i), 72'(bus.if_rsp_data), 72'(vecs[i].e_rd));
            if (vecs[i].e_ctl[0] && vecs[i].chk_rd)
                chk($sformatf("vec%0d_dm_data", i), 72'(bus.dm_rsp_rdata), 72'(vecs[i].e_rd));
            tick();
        end
        chk("table_end_state", 72'(dbg_state), 72'(S_IDLE));
        chk("table_end_starve", 72'(dbg_starve_cnt), 72'(0));

        // ---------------- starvation ----------------
        idle_inputs();
        bus.if_req_valid = 1'b1;
        bus.if_req_addr  = 32'h1000;
        bus.dm_req_valid = 1'b1;
        bus.dm_req_addr  = 32'h2000;
        bus.dm_req_be    = 4'hF;
        pend   = 1'b0;
        grants = 0;
        for (int cyc = 0; cyc < 60 && grants < 6; cyc++) begin
            bus.mem_req_ready = 1'b1;
            bus.mem_rsp_valid = pend;
            @(negedge clk);
            gi = bus.if_req_ready;
            gd = bus.dm_req_ready;
            nxt_pend = bus.mem_req_valid;
            tick();
            pend = nxt_pend;
            if (gi || gd) begin
                chk($sformatf("starve_grant%0d_is_if", grants), 72'(gi), 72'(exp_if_grant[grants]));
                chk($sformatf("starve_grant%0d_cnt", grants), 72'(dbg_starve_cnt), 72'(exp_cnt[grants]));
                grants++;
                if (grants == 6) begin
                    bus.if_req_valid = 1'b0;
                    bus.dm_req_valid = 1'b0;
                end
            end
        end
        chk("starve_grants", 72'(grants), 72'(6));
        for (int d = 0; d < 3; d++) begin
            bus.mem_req_ready = 1'b1;
            bus.mem_rsp_valid = pend;
            @(negedge clk);
            nxt_pend = bus.mem_req_valid;
            tick();
            pend = nxt_pend;
        end
        idle_inputs();
        @(negedge clk);
        chk("starve_drain_state", 72'(dbg_state), 72'(S_IDLE));
        tick();

        // ---------------- back-pressure ----------------
        bus.dm_req_valid = 1'b1;
        bus.dm_req_addr  = 32'h240;
        bus.dm_req_we    = 1'b1;
        bus.dm_req_be    = 4'b1100;
        bus.dm_req_wdata = 32'hA5A5A5A5;
        @(negedge clk);
        chk("bp_accept", 72'(ctl()), 72'(5'b01000));
        tick();
        bus.if_req_valid = 1'b1;
        bus.if_req_addr  = 32'h1100;
        bus.dm_req_addr  = 32'h244;
        bus.dm_req_we    = 1'b0;
        bus.dm_req_wdata = 32'h0;
        for (int i = 0; i < 5; i++) begin
            bus.mem_rsp_valid = (i == 2);   // stray response while in REQ
            @(negedge clk);
            chk($sformatf("bp%0d_ctl", i), 72'(ctl()), 72'(5'b00100));
            chk($sformatf("bp%0d_payload", i),
                72'({bus.mem_req_addr, bus.mem_req_we, bus.mem_req_be, bus.mem_req_wdata}),
                72'({32'h240, 1'b1, 4'b1100, 32'hA5A5A5A5}));
            tick();
        end
        idle_inputs();
        bus.mem_req_ready = 1'b1;
        @(negedge clk);
        chk("bp_release", 72'(ctl()), 72'(5'b00100));
        tick();
        bus.mem_req_ready = 1'b0;
        bus.mem_rsp_valid = 1'b1;
        @(negedge clk);
        chk("bp_rsp", 72'(ctl()), 72'(5'b00001));
        tick();

        // ---------------- flush ----------------
        idle_inputs();
        bus.if_req_valid = 1'b1;
        bus.if_req_addr  = 32'h300;
        @(negedge clk);
        chk("fl_accept", 72'(ctl()), 72'(5'b10000));
        tick();
        idle_inputs();
        bus.mem_req_ready = 1'b1;
        tick();
        bus.mem_req_ready = 1'b0;
        bus.if_flush = 1'b1;
        @(negedge clk);
        chk("fl_wait_ctl", 72'(ctl()), 72'(5'b00000));
        tick();
        chk("fl_drop_set", 72'(dbg_drop), 72'(1));
        bus.if_flush      = 1'b0;
        bus.mem_rsp_valid = 1'b1;
        bus.mem_rsp_rdata = 32'h11111111;
        @(negedge clk);
        chk("fl_swallowed", 72'(ctl()), 72'(5'b00000));
        tick();
        chk("fl_drop_clear", 72'(dbg_drop), 72'(0));
        chk("fl_idle", 72'(dbg_state), 72'(S_IDLE));
        idle_inputs();
        bus.if_req_valid = 1'b1;
        bus.if_req_addr  = 32'h400;
        @(negedge clk);
        chk("fl2_accept", 72'(ctl()), 72'(5'b10000));
        tick();
        idle_inputs();
        bus.mem_req_ready = 1'b1;
        @(negedge clk);
        chk("fl2_addr", 72'(bus.mem_req_addr), 72'(32'h400));
        tick();
        idle_inputs();
        bus.mem_rsp_valid = 1'b1;
        bus.mem_rsp_rdata = 32'h22222222;
        @(negedge clk);
        chk("fl2_rsp", 72'(ctl()), 72'(5'b00010));
        chk("fl2_data", 72'(bus.if_rsp_data), 72'(32'h22222222));
        tick();
        // flush coinciding with the response cycle
        idle_inputs();
        bus.if_req_valid = 1'b1;
        bus.if_req_addr  = 32'h500;
        tick();
        idle_inputs();
        bus.mem_req_ready = 1'b1;
        tick();
        idle_inputs();
        bus.if_flush      = 1'b1;
        bus.mem_rsp_valid = 1'b1;
        bus.mem_rsp_rdata = 32'h33333333;
        @(negedge clk);
        chk("fl3_same_cycle", 72'(ctl()), 72'(5'b00000));
        tick();
        chk("fl3_drop", 72'(dbg_drop), 72'(0));

        // ---------------- reset mid-transaction ----------------
        idle_inputs();
        bus.dm_req_valid = 1'b1;
        bus.dm_req_addr  = 32'h600;
        bus.dm_req_be    = 4'hF;
        @(negedge clk);
        chk("rs_accept", 72'(ctl()), 72'(5'b01000));
        tick();
        idle_inputs();
        @(negedge clk);
        chk("rs_in_req", 72'(ctl()), 72'(5'b00100));
        #1 rst_n = 1'b0;
        #1;
        chk("rs_ctl", 72'(ctl()), 72'(5'b00000));
        chk("rs_state", 72'(dbg_state), 72'(S_IDLE));
        chk("rs_regs", 72'({dbg_owner, dbg_drop, dbg_starve_cnt}), 72'(0));
        chk("rs_mem_addr", 72'(bus.mem_req_addr), 72'(0));
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        bus.dm_req_valid = 1'b1;
        bus.dm_req_addr  = 32'h700;
        bus.dm_req_be    = 4'hF;
        @(negedge clk);
        chk("rs2_accept", 72'(ctl()), 72'(5'b01000));
        tick();
        idle_inputs();
        bus.mem_req_ready = 1'b1;
        @(negedge clk);
        chk("rs2_addr", 72'(bus.mem_req_addr), 72'(32'h700));
        tick();
        idle_inputs();
        bus.mem_rsp_valid = 1'b1;
        bus.mem_rsp_rdata = 32'h77777777;
        @(negedge clk);
        chk("rs2_rsp", 72'(ctl()), 72'(5'b00001));
        chk("rs2_data", 72'(bus.dm_rsp_rdata), 72'(32'h77777777));
        tick();
        idle_inputs();
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
